// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss handler for the 8-way set-associative D-cache.
// For each accepted miss it picks the pLRU victim and writes it back if it
// is valid and dirty. It then refills the line beat by beat, writes the new
// tag and strobes the pLRU update for the filled way.
`timescale 1ns/1ps
module cache_miss_ctrl #(
  parameter int INDEX     = 4,
  parameter int INDEX_WAY = 3,
  parameter int BEATS     = 4,
  parameter int ADDR_W    = 32,
  localparam int BW       = $clog2(BEATS),
  localparam int OFF      = BW + 2,
  localparam int TAG_W    = ADDR_W - INDEX - OFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 miss_valid_i,
  output logic                 miss_ready_o,
  input  logic [INDEX-1:0]     miss_index_i,
  input  logic [TAG_W-1:0]     miss_tag_i,
  output logic [INDEX-1:0]     lru_index_o,
  input  logic [INDEX_WAY-1:0] victim_way_i,
  input  logic                 victim_valid_i,
  input  logic                 victim_dirty_i,
  input  logic [TAG_W-1:0]     victim_tag_i,
  output logic                 lru_valid_o,
  output logic [INDEX_WAY-1:0] lru_way_o,
  output logic [INDEX_WAY-1:0] arr_way_o,
  output logic [BW-1:0]        arr_beat_o,
  input  logic [31:0]          arr_rdata_i,
  output logic                 arr_we_o,
  output logic [31:0]          arr_wdata_o,
  output logic                 tag_we_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    WB      = 3'd2,
    RF_REQ  = 3'd3,
    RF_WAIT = 3'd4,
    UPD     = 3'd5
  } state_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t               state;
  logic [BW-1:0]        beat;
  logic [INDEX-1:0]     set_index;
  logic [TAG_W-1:0]     miss_tag;
  logic [INDEX_WAY-1:0] victim_way;
  logic [TAG_W-1:0]     victim_tag;

  logic [BW-1:0]        beat_next;
  logic                 last_beat;

  // A line word address is simply {tag, set, word, byte offset}.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [INDEX-1:0] s,
                                                  input logic [BW-1:0]    b);
    return {t, s, b, 2'b00};
  endfunction

  assign beat_next = beat + BW'(1);
  assign last_beat = (beat == LAST_BEAT);

  // While idle the pLRU sees the incoming set so the victim is ready by LATCH;
  // once busy it must keep looking at the set being serviced.
  assign lru_index_o = (state == IDLE) ? miss_index_i : set_index;

  // In LATCH the victim has not been registered yet, so show it straight through.
  assign arr_way_o   = (state == LATCH) ? victim_way_i : victim_way;
  assign arr_beat_o  = beat;
  assign tag_o       = miss_tag;

  // Refill words go straight from the memory read port into the data array.
  assign arr_we_o    = (state == RF_WAIT) && mem_rvalid_i;
  assign arr_wdata_o = arr_we_o ? mem_rdata_i : '0;

  // Write-back data is the array word currently addressed by way/beat.
  assign mem_wdata_o = (state == WB) ? arr_rdata_i : '0;

  // Miss-handling sequencer; every handshake output is registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      beat         <= '0;
      set_index    <= '0;
      miss_tag     <= '0;
      victim_way   <= '0;
      victim_tag   <= '0;
      miss_ready_o <= 1'b1;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      tag_we_o     <= 1'b0;
      lru_valid_o  <= 1'b0;
      lru_way_o    <= '0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid_i && miss_ready_o) begin
            set_index    <= miss_index_i;
            miss_tag     <= miss_tag_i;
            miss_ready_o <= 1'b0;
            state        <= LATCH;
          end
        end

        LATCH: begin
          victim_way <= victim_way_i;
          victim_tag <= victim_tag_i;
          beat       <= '0;
          mem_req_o  <= 1'b1;
          if (victim_valid_i && victim_dirty_i) begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= line_addr(victim_tag_i, set_index, '0);
            state      <= WB;
          end else begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= line_addr(miss_tag, set_index, '0);
            state      <= RF_REQ;
          end
        end

        WB: begin
          if (mem_gnt_i) begin
            if (last_beat) begin
              beat       <= '0;
              mem_we_o   <= 1'b0;
              mem_addr_o <= line_addr(miss_tag, set_index, '0);
              state      <= RF_REQ;
            end else begin
              beat       <= beat_next;
              mem_addr_o <= line_addr(victim_tag, set_index, beat_next);
            end
          end
        end

        RF_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RF_WAIT;
          end
        end

        RF_WAIT: begin
          if (mem_rvalid_i) begin
            if (last_beat) begin
              beat        <= '0;
              mem_addr_o  <= '0;
              tag_we_o    <= 1'b1;
              lru_valid_o <= 1'b1;
              lru_way_o   <= victim_way;
              done_o      <= 1'b1;
              state       <= UPD;
            end else begin
              beat       <= beat_next;
              mem_req_o  <= 1'b1;
              mem_addr_o <= line_addr(miss_tag, set_index, beat_next);
              state      <= RF_REQ;
            end
          end
        end

        UPD: begin
          tag_we_o     <= 1'b0;
          lru_valid_o  <= 1'b0;
          lru_way_o    <= '0;
          done_o       <= 1'b0;
          miss_ready_o <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          mem_req_o    <= 1'b0;
          mem_we_o     <= 1'b0;
          miss_ready_o <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  // A stalled request must keep its address and direction until granted.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o) && $stable(mem_we_o)));

  // Completion always carries the tag write and the pLRU strobe with it.
  assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |-> (tag_we_o && lru_valid_o && !miss_ready_o));

  // Only one read is ever outstanding, so no request overlaps a refill write.
  assert property (@(posedge clk_i) disable iff (rst_i)
    arr_we_o |-> !mem_req_o);

endmodule
